// File: rtl/tester_frame_gen.sv
// Per-port transmit generator: snapshots the port config on start and streams
// back-to-back IPv4 test frames (TOS 0xDE, proto 0xFD) on a 64-bit AXI-Stream.

package tester_frame_gen_pkg;
    typedef struct packed {
        logic        enable;
        logic [15:0] frame_size;
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } port_config_t;
endpackage

// Ones'-complement IPv4 header checksum over ten 16-bit words (checksum field zero).
module ip_header_checksum (
    input  logic [159:0] hdr_i,
    output logic [15:0]  csum_o
);
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + 20'(hdr_i[16*i +: 16]);
        end
        fold1  = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold2  = fold1[15:0] + 16'(fold1[16]);
        csum_o = ~fold2;
    end
endmodule

module tester_frame_gen
    import tester_frame_gen_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned IP_TTL    = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  port_config_t cfg,
    input  logic         start,
    input  logic         stop,
    output logic         busy,
    output logic         done,
    output logic [63:0]  m_tdata,
    output logic [7:0]   m_tkeep,
    output logic         m_tlast,
    output logic         m_tuser,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [31:0]  tx_frames,
    output logic [31:0]  tx_bytes
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned BEAT_W = LEN_W - 3;
    localparam int unsigned HDR_B  = 38;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    state_e             state_q;
    logic [47:0]        dst_mac_q, src_mac_q;
    logic [31:0]        src_ip_q, dst_ip_q;
    logic [LEN_W-1:0]   len_q;
    logic [BEAT_W-1:0]  last_beat_q, beat_q;
    logic [7:0]         keep_last_q;
    logic [31:0]        seq_q, frames_q, bytes_q;
    logic               stop_req_q, busy_q, done_q;
    logic               m_tvalid_q, m_tlast_q;
    logic [63:0]        m_tdata_q;
    logic [7:0]         m_tkeep_q;

    logic [LEN_W-1:0]   len_c, tot_len_c;
    logic [159:0]       ip_hdr_c;
    logic [15:0]        csum_c;
    logic [8*HDR_B-1:0] frame_hdr_c;
    logic [7:0]         hdr_bytes_c [HDR_B];
    logic [BEAT_W-1:0]  nxt_beat_c;
    logic               nxt_last_c;
    logic [7:0]         nxt_keep_c;
    logic [63:0]        beat_data_c;

    // Effective length and the keep mask of the final beat, derived at start
    assign len_c     = (cfg.frame_size < LEN_W'(MIN_FRAME)) ? LEN_W'(MIN_FRAME) : cfg.frame_size;
    assign tot_len_c = len_q - LEN_W'(14);

    assign ip_hdr_c = {8'h45, 8'hDE, tot_len_c, seq_q[15:0], 16'h4000, 8'(IP_TTL), 8'hFD,
                       16'h0000, src_ip_q, dst_ip_q};

    ip_header_checksum u_csum (
        .hdr_i  (ip_hdr_c),
        .csum_o (csum_c)
    );

    assign frame_hdr_c = {dst_mac_q, src_mac_q, 16'h0800,
                          8'h45, 8'hDE, tot_len_c, seq_q[15:0], 16'h4000, 8'(IP_TTL), 8'hFD,
                          csum_c, src_ip_q, dst_ip_q, seq_q};

    // Beat to load next: beat 0 carries no seq-dependent bytes, so it may be
    // built before seq_q advances at a frame boundary.
    assign nxt_beat_c = (state_q == SEND && !m_tlast_q) ? beat_q + BEAT_W'(1) : '0;
    assign nxt_last_c = (nxt_beat_c == last_beat_q);
    assign nxt_keep_c = nxt_last_c ? keep_last_q : 8'hFF;

    always_comb begin
        for (int j = 0; j < HDR_B; j++) begin
            hdr_bytes_c[j] = frame_hdr_c[8*(HDR_B-1-j) +: 8];
        end
    end

    always_comb begin
        logic [LEN_W-1:0] k;
        beat_data_c = '0;
        for (int i = 0; i < 8; i++) begin
            k = {nxt_beat_c, 3'(i)};
            if (k < LEN_W'(HDR_B)) beat_data_c[8*i +: 8] = hdr_bytes_c[k[5:0]];
            else                   beat_data_c[8*i +: 8] = k[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dst_mac_q   <= '0;
            src_mac_q   <= '0;
            src_ip_q    <= '0;
            dst_ip_q    <= '0;
            len_q       <= '0;
            last_beat_q <= '0;
            keep_last_q <= '0;
            beat_q      <= '0;
            seq_q       <= '0;
            frames_q    <= '0;
            bytes_q     <= '0;
            stop_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && cfg.enable) begin
                        dst_mac_q   <= cfg.dst_mac;
                        src_mac_q   <= cfg.src_mac;
                        src_ip_q    <= cfg.src_ip;
                        dst_ip_q    <= cfg.dst_ip;
                        len_q       <= len_c;
                        last_beat_q <= BEAT_W'((len_c - LEN_W'(1)) >> 3);
                        keep_last_q <= (len_c[2:0] == 3'd0) ? 8'hFF
                                                            : 8'(8'hFF >> (4'd8 - 4'(len_c[2:0])));
                        frames_q    <= '0;
                        bytes_q     <= '0;
                        seq_q       <= '0;
                        stop_req_q  <= stop;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    if (stop) stop_req_q <= 1'b1;
                    m_tvalid_q <= 1'b1;
                    m_tdata_q  <= beat_data_c;
                    m_tkeep_q  <= nxt_keep_c;
                    m_tlast_q  <= nxt_last_c;
                    beat_q     <= nxt_beat_c;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (stop) stop_req_q <= 1'b1;
                    if (m_tvalid_q && m_tready) begin
                        if (m_tlast_q) begin
                            frames_q <= frames_q + 32'd1;
                            bytes_q  <= bytes_q + 32'(len_q);
                            seq_q    <= seq_q + 32'd1;
                        end
                        if (m_tlast_q && (stop_req_q || stop)) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            stop_req_q <= 1'b0;
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            m_tkeep_q  <= '0;
                            m_tdata_q  <= '0;
                            beat_q     <= '0;
                        end else begin
                            beat_q    <= nxt_beat_c;
                            m_tdata_q <= beat_data_c;
                            m_tkeep_q <= nxt_keep_c;
                            m_tlast_q <= nxt_last_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign m_tdata   = m_tdata_q;
    assign m_tkeep   = m_tkeep_q;
    assign m_tlast   = m_tlast_q;
    assign m_tuser   = 1'b0;
    assign m_tvalid  = m_tvalid_q;
    assign tx_frames = frames_q;
    assign tx_bytes  = bytes_q;
endmodule

// File: tb/tb_tester_frame_gen.sv
// Randomized bench for tester_frame_gen: received frames are compared against
// a byte-level reference built from the frame layout rules.

module tb_tester_frame_gen;
    import tester_frame_gen_pkg::*;

    typedef logic [7:0] bq_t [$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    port_config_t cfg;
    logic         start = 1'b0, stop = 1'b0;
    logic         busy, done, m_tlast, m_tuser, m_tvalid;
    logic         m_tready = 1'b1;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic [31:0]  tx_frames, tx_bytes;

    tester_frame_gen #(.MIN_FRAME(60), .IP_TTL(64)) dut (
        .clk(clk), .rst_n(rst_n), .cfg(cfg), .start(start), .stop(stop),
        .busy(busy), .done(done), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .tx_frames(tx_frames), .tx_bytes(tx_bytes)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    port_config_t run_cfg;
    int unsigned  run_seq = 0;
    bit           tready_rand = 1'b0;

    bq_t          cur, last_frame;
    int           beats = 0, last_beats = 0, rx_frames = 0, sof_cnt = 0, done_cnt = 0;
    logic [7:0]   last_keep = '0;
    bit           prev_eof = 1'b0, prev_stall = 1'b0;
    logic [63:0]  prev_data = '0;
    logic [8:0]   prev_ctl = '0;

    function automatic int unsigned len_of(input port_config_t c);
        return (c.frame_size < 16'd60) ? 60 : int'(c.frame_size);
    endfunction

    function automatic bq_t model_frame(input port_config_t c, input int unsigned seq);
        bq_t f;
        int unsigned L = len_of(c);
        int unsigned w[10];
        int unsigned s = 0;
        w = '{32'h45DE, L - 14, seq & 32'hFFFF, 32'h4000, 32'h40FD, 0,
              c.src_ip >> 16, c.src_ip & 32'hFFFF, c.dst_ip >> 16, c.dst_ip & 32'hFFFF};
        foreach (w[i]) s += w[i];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        w[5] = (~s) & 32'hFFFF;
        for (int i = 5; i >= 0; i--) f.push_back(c.dst_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(c.src_mac[8*i +: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        for (int i = 0; i < 10; i++) begin
            f.push_back(8'(w[i] >> 8));
            f.push_back(8'(w[i]));
        end
        for (int i = 3; i >= 0; i--) f.push_back(8'(seq >> (8*i)));
        for (int unsigned k = 38; k < L; k++) f.push_back(8'(k));
        return f;
    endfunction

    function automatic port_config_t rand_cfg(input int unsigned size);
        port_config_t c;
        c.enable     = 1'b1;
        c.frame_size = 16'(size);
        c.dst_mac    = 48'({$urandom(), $urandom()});
        c.src_mac    = 48'({$urandom(), $urandom()});
        c.src_ip     = $urandom();
        c.dst_ip     = $urandom();
        return c;
    endfunction

    task automatic check_frame();
        bq_t exp = model_frame(run_cfg, run_seq);
        int unsigned L = len_of(run_cfg);
        int unsigned r = L % 8;
        int n = (cur.size() < exp.size()) ? cur.size() : exp.size();
        int idx = n - 1;
        chk("frame_len", 64'(cur.size()), 64'(exp.size()));
        chk("frame_beats", 64'(beats), 64'((L + 7) / 8));
        chk("frame_last_keep", 64'(m_tkeep), (r == 0) ? 64'hFF : 64'((1 << r) - 1));
        for (int i = n - 1; i >= 0; i--) if (cur[i] !== exp[i]) idx = i;
        if (n > 0) chk($sformatf("frame_data[%0d]", idx), 64'(cur[idx]), 64'(exp[idx]));
        last_frame = cur;
        last_beats = beats;
        last_keep  = m_tkeep;
        rx_frames++;
        run_seq++;
        cur.delete();
        beats = 0;
    endtask

    // Stream monitor: sampled on the falling edge, handshakes complete on the next rise
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cur.delete();
            beats = 0; prev_eof = 1'b0; prev_stall = 1'b0;
        end else begin
            if (prev_eof && busy) chk("no_gap", 64'(m_tvalid), 64'd1);
            if (prev_stall) begin
                chk("hold_data", m_tdata, prev_data);
                chk("hold_ctl", 64'({m_tvalid, m_tlast, m_tkeep}), 64'({1'b1, prev_ctl}));
            end
            prev_eof   = 1'b0;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_ctl   = {m_tlast, m_tkeep};
            if (done) done_cnt++;
            if (m_tvalid && m_tready) begin
                chk("tuser", 64'(m_tuser), 64'd0);
                if (beats == 0) sof_cnt++;
                beats++;
                for (int i = 0; i < 8; i++) if (m_tkeep[i]) cur.push_back(m_tdata[8*i +: 8]);
                if (m_tlast) begin
                    check_frame();
                    prev_eof = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        m_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic kick(input port_config_t c, input bit with_stop);
        @(posedge clk); #1;
        cfg = c; start = 1'b1; stop = with_stop;
        if (c.enable) begin run_cfg = c; run_seq = 0; end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
        if (done_cnt == d0) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [15:0] hdr_sum(input bq_t f);
        int unsigned s = 0;
        for (int i = 14; i < 34; i += 2) s += {f[i], f[i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    initial begin
        port_config_t c;
        int d0, r0, s0, n;
        cfg = rand_cfg(60);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_tvalid", 64'(m_tvalid), 0);
        chk("rst_tlast_tkeep", 64'({m_tlast, m_tkeep}), 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_counters", {tx_frames, tx_bytes}, 0);
        rst_n = 1'b1;

        // Minimum frame, start and stop together
        c = rand_cfg(60); d0 = done_cnt; r0 = rx_frames;
        kick(c, 1'b1);
        wait_done("t1", 200);
        repeat (5) @(negedge clk);
        chk("t1_done_once", 64'(done_cnt - d0), 1);
        chk("t1_frames_rx", 64'(rx_frames - r0), 1);
        chk("t1_tx_frames", 64'(tx_frames), 1);
        chk("t1_tx_bytes", 64'(tx_bytes), 60);
        chk("t1_beats", 64'(last_beats), 8);
        chk("t1_last_keep", 64'(last_keep), 64'h0F);
        chk("t1_ip_len", 64'({last_frame[16], last_frame[17]}), 64'h002E);
        chk("t1_ip_id", 64'({last_frame[18], last_frame[19]}), 0);
        chk("t1_csum_valid", 64'(hdr_sum(last_frame)), 64'hFFFF);

        // Runt clamp and disabled start
        c = rand_cfg(10);
        kick(c, 1'b1);
        wait_done("t2", 200);
        chk("t2_runt_len", 64'(last_frame.size()), 60);
        chk("t2_runt_bytes", 64'(tx_bytes), 60);
        c = rand_cfg(0); c.enable = 1'b0; r0 = rx_frames;
        kick(c, 1'b0);
        repeat (20) @(negedge clk);
        chk("t2_dis_busy", 64'(busy), 0);
        chk("t2_dis_tvalid", 64'(m_tvalid), 0);
        chk("t2_dis_frames", 64'(rx_frames - r0), 0);

        // Continuous run, stop during the fifth frame
        c = rand_cfg(1000); r0 = rx_frames; s0 = sof_cnt;
        kick(c, 1'b0);
        n = 0;
        while (sof_cnt - s0 < 5 && n < 3000) begin @(negedge clk); n++; end
        chk("t3_sof_reached", 64'(sof_cnt - s0 >= 5), 1);
        pulse_stop();
        wait_done("t3", 1000);
        chk("t3_frames_rx", 64'(rx_frames - r0), 5);
        chk("t3_tx_frames", 64'(tx_frames), 5);
        chk("t3_tx_bytes", 64'(tx_bytes), 5000);
        chk("t3_beats", 64'(last_beats), 125);
        chk("t3_last_keep", 64'(last_keep), 64'hFF);
        chk("t3_last_id", 64'({last_frame[18], last_frame[19]}), 4);

        // Backpressure, then randomized sizes under backpressure
        tready_rand = 1'b1;
        c = rand_cfg(129);
        kick(c, 1'b1);
        wait_done("t4", 2000);
        chk("t4_beats", 64'(last_beats), 17);
        chk("t4_last_keep", 64'(last_keep), 64'h01);
        chk("t4_byte128", 64'(last_frame[128]), 64'h80);
        for (int it = 0; it < 6; it++) begin
            c = rand_cfg($urandom_range(0, 300));
            kick(c, 1'b1);
            wait_done("t4r", 4000);
            chk("t4r_tx_frames", 64'(tx_frames), 1);
            chk("t4r_tx_bytes", 64'(tx_bytes), 64'(len_of(c)));
        end
        tready_rand = 1'b0;

        // Second start and cfg change during a run are ignored
        c = rand_cfg(100); r0 = rx_frames;
        kick(c, 1'b0);
        repeat (5) @(posedge clk);
        #1; cfg.dst_ip = ~cfg.dst_ip; cfg.frame_size = 16'd300; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (rx_frames - r0 < 2 && n < 500) begin @(negedge clk); n++; end
        pulse_stop();
        wait_done("t5", 500);
        chk("t5_frames_match", 64'(tx_frames), 64'(rx_frames - r0));
        chk("t5_bytes", 64'(tx_bytes), 64'(tx_frames * 100));

        // Asynchronous reset mid-frame, then a fresh run starts at seq 0
        c = rand_cfg(200);
        kick(c, 1'b0);
        repeat (10) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_tvalid), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        chk("t6_rst_frames", 64'(tx_frames), 0);
        c = rand_cfg(64);
        kick(c, 1'b1);
        wait_done("t6", 200);
        chk("t6_tx_frames", 64'(tx_frames), 1);
        chk("t6_id", 64'({last_frame[18], last_frame[19]}), 0);
        chk("t6_seq", 64'({last_frame[34], last_frame[35], last_frame[36], last_frame[37]}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tester_frame_gen.md
Name: tester_frame_gen

Overview:
- Per-port transmit generator for the speed tester.
- On start, snapshots the port configuration and emits back-to-back IPv4 test frames (TOS 0xDE, proto 0xFD) on a 64-bit AXI-Stream toward the MAC TX path.
- IPv4 header checksum comes from an instance of ip_header_checksum.
- Keeps sent-frame and sent-byte counters that complement the receiver's port_result_t statistics.

Parameters:
- MIN_FRAME, 60: minimum frame length in bytes, excluding FCS; smaller configured sizes are raised to this.
- IP_TTL, 64: TTL written into every header.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous active-low reset.
- cfg  in  port_config_t  port configuration; sampled only on accepted start.
- start  in  1  one-cycle start pulse.
- stop  in  1  one-cycle stop request.
- busy  out  1  high from accepted start until the final tlast handshake.
- done  out  1  one-cycle pulse in the cycle after the final tlast handshake.
- m_tdata  out  64  byte i of the beat is in bits [8i+7:8i]; beat n carries frame bytes 8n..8n+7.
- m_tkeep  out  8  contiguous from bit 0.
- m_tlast  out  1  last beat of the frame.
- m_tuser  out  1  always 0.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- tx_frames  out  32  frames fully sent since the last accepted start.
- tx_bytes  out  32  bytes sent since the last accepted start, excluding FCS.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, stop_req 0, seq 0. Reset is asynchronous; asserting it mid-frame drops tvalid immediately with no tlast, and the partial frame is abandoned.
- FSM states:
  - IDLE: busy=0. start with cfg.enable=1 latches cfg into a snapshot, computes L = max(cfg.frame_size, MIN_FRAME), clears tx_frames, tx_bytes and seq, then goes to SEND. start with enable=0 is ignored.
  - SEND: busy=1. First tvalid appears no later than 2 cycles after start. The beat index advances only on tvalid&tready. While tvalid=1 and tready=0, tdata, tkeep and tlast are held stable.
- Frame length: L bytes, giving ceil(L/8) beats. On the last beat tlast=1 and tkeep = (1<<(L mod 8))-1, or 0xFF when L mod 8 = 0. All other beats have tkeep=0xFF.
- Frame layout (network byte order):
  - Bytes 0-5: dst_mac. 6-11: src_mac. 12-13: 0x0800.
  - Bytes 14-33: IPv4 header with version 4, IHL 5, TOS 0xDE, total length L-14, id = seq[15:0], DF=1, MF=0, offset 0, TTL IP_TTL, proto 0xFD, standard header checksum, src_ip, dst_ip.
  - Bytes 34-37: seq[31:0], big-endian.
  - Byte k for k>=38: k[7:0].
- End of frame (tlast handshake): tx_frames += 1, tx_bytes += L, seq += 1. Then:
  - if stop_req, or stop is asserted in this same cycle: go to IDLE, pulse done, clear stop_req;
  - otherwise the next frame's first beat is presented in the next cycle, with no idle gap.
- stop:
  - in SEND, sets stop_req; the current frame always completes.
  - in IDLE, has no effect, except when start and stop arrive in the same cycle: then stop_req is set and exactly one frame is sent.
- start while busy is ignored, and cfg changes while busy have no effect on the run.
- Counters and seq wrap modulo 2^32 silently.
- The snapshot and beat data are registered, so header bytes and checksum do not depend combinationally on cfg.

Test Plan:
- 60-byte frame: cfg frame_size=60, enable=1, start and stop in the same cycle, tready=1 → 8 beats, beat 7 tkeep=0x0F and tlast=1; IP len 0x002E, id 0, checksum validates to 0xFFFF in a ones'-complement sum; done pulses once; tx_frames=1, tx_bytes=60.
- Runt clamp: frame_size=10 → frame is 60 bytes; frame_size=0 with enable=0 → no output, busy stays 0.
- Continuous run: frame_size=1000, stop asserted after the 5th frame's first beat → exactly 5 frames of 125 beats each (last tkeep 0xFF) and zero gap between frames; ids 0..4; tx_bytes=5000.
- Backpressure: frame_size=129 with random tready at 50% → data is held while stalled; 17 beats with last tkeep=0x01; byte 128 = 0x80; payload sequence is intact.
- Mid-run robustness: a second start and a cfg.dst_ip change during a run → frames are unaffected. Reset asserted mid-frame → tvalid=0 and busy=0 immediately; a new start begins at seq 0.
